// File: rtl/dm_access_arbiter_pkg.sv
// Shared data-memory types: load type codes, arbiter FSM states and the
// captured request record used by dm_access_arbiter.
package dm_pkg;

  localparam int unsigned DM_XLEN = 64;

  typedef enum logic [2:0] {
    LOAD_B  = 3'd0,
    LOAD_H  = 3'd1,
    LOAD_W  = 3'd2,
    LOAD_BU = 3'd3,
    LOAD_HU = 3'd4,
    LOAD_WU = 3'd5,
    LOAD_D  = 3'd6
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [DM_XLEN-1:0] addr;
    logic [DM_XLEN-1:0] wdata;
    load_type_e         load_type;
  } dm_req_t;

  localparam dm_req_t DM_REQ_ZERO = dm_req_t'({$bits(dm_req_t){1'b0}});

  // Packs one requester's payload into a request record.
  function automatic dm_req_t make_req(
    input logic               we,
    input logic [DM_XLEN-1:0] addr,
    input logic [DM_XLEN-1:0] wdata,
    input load_type_e         load_type
  );
    dm_req_t r;
    r.we        = we;
    r.addr      = addr;
    r.wdata     = wdata;
    r.load_type = load_type;
    return r;
  endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Bus bundle of dm_access_arbiter: two requester ports, their response
// strobes, and the shared data-memory access port.
// slave  = the arbiter side, master = the requesters/memory environment.
interface dm_access_arbiter_if #(
  parameter int unsigned XLEN = dm_pkg::DM_XLEN
);

  logic            req0_valid;
  logic            req0_ready;
  logic            req0_we;
  logic [XLEN-1:0] req0_addr;
  logic [XLEN-1:0] req0_wdata;
  logic [2:0]      req0_load_type;
  logic            rsp0_valid;
  logic [XLEN-1:0] rsp0_rdata;

  logic            req1_valid;
  logic            req1_ready;
  logic            req1_we;
  logic [XLEN-1:0] req1_addr;
  logic [XLEN-1:0] req1_wdata;
  logic [2:0]      req1_load_type;
  logic            rsp1_valid;
  logic [XLEN-1:0] rsp1_rdata;

  logic            dm_read_enable;
  logic            dm_write_enable;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_write_data;
  logic [2:0]      dm_load_type;
  logic [XLEN-1:0] dm_read_data;
  logic            busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_load_type,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_load_type,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output dm_read_enable, dm_write_enable, dm_addr, dm_write_data, dm_load_type,
    input  dm_read_data,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_load_type,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_load_type,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  dm_read_enable, dm_write_enable, dm_addr, dm_write_data, dm_load_type,
    output dm_read_data,
    input  busy
  );

endinterface

// File: rtl/dm_access_arbiter_select.sv
// dm_arb_select: combinational winner/grant logic for dm_access_arbiter.
// Default: fixed priority, port 0 over port 1.
// With DM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request the port
// that did not win last time wins; a lone requester always wins.
module dm_arb_select (
  input  logic enable,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic last_grant,
  output logic ready0,
  output logic ready1,
  output logic grant_port
);

`ifndef DM_ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Pick at most one winner; no grant at all while the arbiter is not idle.
  always_comb begin
    ready0     = 1'b0;
    ready1     = 1'b0;
    grant_port = 1'b0;
    if (enable) begin
      if (req0_valid && req1_valid) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (last_grant) begin
          ready0     = 1'b1;
          grant_port = 1'b0;
        end else begin
          ready1     = 1'b1;
          grant_port = 1'b1;
        end
`else
        ready0     = 1'b1;
        grant_port = 1'b0;
`endif
      end else if (req0_valid) begin
        ready0     = 1'b1;
        grant_port = 1'b0;
      end else if (req1_valid) begin
        ready1     = 1'b1;
        grant_port = 1'b1;
      end else begin
        ready0     = 1'b0;
        ready1     = 1'b0;
      end
    end else begin
      ready0 = 1'b0;
      ready1 = 1'b0;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the single data-memory access path between the
// MEM-stage load/store (port 0) and the debug/DMA master (port 1).
// One access at a time: IDLE (grant) -> ACCESS (MEM_LATENCY cycles, memory
// port held stable) -> RESP (one-cycle response strobe) -> IDLE.
// Optional macro DM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned XLEN        = DM_XLEN,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  dm_access_arbiter_if.slave bus
);

  // lat_cnt counts down to zero across the ACCESS cycles (1..4 of them).
  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

  arb_state_e      state_r;
  arb_state_e      state_next_s;
  logic [1:0]      lat_cnt_r;
  logic            last_grant_r;
  logic            owner_r;
  dm_req_t         req_r;

  dm_req_t         req0_s;
  dm_req_t         req1_s;
  dm_req_t         req_sel_s;
  logic            arb_enable_s;
  logic            ready0_s;
  logic            ready1_s;
  logic            grant_s;
  logic            accept_s;
  logic            access_last_s;
  logic [XLEN-1:0] rsp_data_s;

  logic            rsp0_valid_r;
  logic            rsp1_valid_r;
  logic [XLEN-1:0] rsp0_rdata_r;
  logic [XLEN-1:0] rsp1_rdata_r;

  logic            dm_read_enable_s;
  logic            dm_write_enable_s;
  logic [XLEN-1:0] dm_addr_s;
  logic [XLEN-1:0] dm_write_data_s;
  logic [2:0]      dm_load_type_s;

  assign req0_s = make_req(bus.req0_we, DM_XLEN'(bus.req0_addr),
                           DM_XLEN'(bus.req0_wdata), load_type_e'(bus.req0_load_type));
  assign req1_s = make_req(bus.req1_we, DM_XLEN'(bus.req1_addr),
                           DM_XLEN'(bus.req1_wdata), load_type_e'(bus.req1_load_type));

  // Grants are only offered from IDLE, and never while reset is asserted.
  assign arb_enable_s = (state_r == IDLE) && rst_n;

  dm_arb_select u_select (
    .enable     (arb_enable_s),
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .last_grant (last_grant_r),
    .ready0     (ready0_s),
    .ready1     (ready1_s),
    .grant_port (grant_s)
  );

  assign accept_s      = ready0_s | ready1_s;
  assign access_last_s = (state_r == ACCESS) && (lat_cnt_r == 2'd0);

  // Route the winning requester's payload to the capture registers.
  always_comb begin
    req_sel_s = req0_s;
    if (grant_s) begin
      req_sel_s = req1_s;
    end else begin
      req_sel_s = req0_s;
    end
  end

  // Stores answer with zero data; loads return the memory word.
  always_comb begin
    rsp_data_s = {XLEN{1'b0}};
    if (req_r.we) begin
      rsp_data_s = {XLEN{1'b0}};
    end else begin
      rsp_data_s = bus.dm_read_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: grant -> ACCESS, countdown done -> RESP, then IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (lat_cnt_r == 2'd0) begin
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request capture, latency countdown, grant history and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r        <= DM_REQ_ZERO;
      owner_r      <= 1'b0;
      lat_cnt_r    <= 2'd0;
      last_grant_r <= 1'b1;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {XLEN{1'b0}};
      rsp1_rdata_r <= {XLEN{1'b0}};
    end else begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {XLEN{1'b0}};
      rsp1_rdata_r <= {XLEN{1'b0}};
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_r        <= req_sel_s;
            owner_r      <= grant_s;
            lat_cnt_r    <= LAT_INIT;
            last_grant_r <= grant_s;
          end else begin
            lat_cnt_r <= 2'd0;
          end
        end
        ACCESS: begin
          if (access_last_s) begin
            if (owner_r) begin
              rsp1_valid_r <= 1'b1;
              rsp1_rdata_r <= rsp_data_s;
            end else begin
              rsp0_valid_r <= 1'b1;
              rsp0_rdata_r <= rsp_data_s;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
          end
        end
        RESP: begin
          lat_cnt_r <= 2'd0;
        end
        default: begin
          lat_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  // Memory port carries the captured request only during ACCESS, else zero.
  always_comb begin
    dm_read_enable_s  = 1'b0;
    dm_write_enable_s = 1'b0;
    dm_addr_s         = {XLEN{1'b0}};
    dm_write_data_s   = {XLEN{1'b0}};
    dm_load_type_s    = 3'd0;
    if (state_r == ACCESS) begin
      dm_read_enable_s  = ~req_r.we;
      dm_write_enable_s = req_r.we;
      dm_addr_s         = req_r.addr[XLEN-1:0];
      dm_write_data_s   = req_r.wdata[XLEN-1:0];
      dm_load_type_s    = req_r.load_type;
    end else begin
      dm_read_enable_s  = 1'b0;
      dm_write_enable_s = 1'b0;
    end
  end

  assign bus.req0_ready      = ready0_s;
  assign bus.req1_ready      = ready1_s;
  assign bus.rsp0_valid      = rsp0_valid_r;
  assign bus.rsp1_valid      = rsp1_valid_r;
  assign bus.rsp0_rdata      = rsp0_rdata_r;
  assign bus.rsp1_rdata      = rsp1_rdata_r;
  assign bus.dm_read_enable  = dm_read_enable_s;
  assign bus.dm_write_enable = dm_write_enable_s;
  assign bus.dm_addr         = dm_addr_s;
  assign bus.dm_write_data   = dm_write_data_s;
  assign bus.dm_load_type    = dm_load_type_s;
  assign bus.busy            = (state_r != IDLE);

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: two instances (MEM_LATENCY 1 and 3) driven by
// directed scenarios and random requester traffic, each checked every cycle
// against a timeline model of the arbiter's externally visible behaviour.
module tb_dm_access_arbiter;
  import dm_pkg::*;

  localparam int unsigned XW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_access_arbiter_if #(.XLEN(XW)) bus_a ();
  dm_access_arbiter_if #(.XLEN(XW)) bus_b ();

  dm_access_arbiter #(.XLEN(XW), .MEM_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dm_access_arbiter #(.XLEN(XW), .MEM_LATENCY(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Stimulus, indexed [dut][port].
  logic          in_valid [2][2];
  logic          in_we    [2][2];
  logic [63:0]   in_addr  [2][2];
  logic [63:0]   in_wdata [2][2];
  logic [2:0]    in_lt    [2][2];
  logic [63:0]   in_rd    [2];

  // Observed outputs.
  logic          o_ready  [2][2];
  logic          o_rv     [2][2];
  logic [63:0]   o_rd     [2][2];
  logic          o_re     [2];
  logic          o_we     [2];
  logic [63:0]   o_addr   [2];
  logic [63:0]   o_wd     [2];
  logic [2:0]    o_lt     [2];
  logic          o_busy   [2];

  assign bus_a.req0_valid = in_valid[0][0];  assign bus_a.req1_valid = in_valid[0][1];
  assign bus_a.req0_we    = in_we[0][0];     assign bus_a.req1_we    = in_we[0][1];
  assign bus_a.req0_addr  = in_addr[0][0];   assign bus_a.req1_addr  = in_addr[0][1];
  assign bus_a.req0_wdata = in_wdata[0][0];  assign bus_a.req1_wdata = in_wdata[0][1];
  assign bus_a.req0_load_type = in_lt[0][0]; assign bus_a.req1_load_type = in_lt[0][1];
  assign bus_a.dm_read_data = in_rd[0];
  assign bus_b.req0_valid = in_valid[1][0];  assign bus_b.req1_valid = in_valid[1][1];
  assign bus_b.req0_we    = in_we[1][0];     assign bus_b.req1_we    = in_we[1][1];
  assign bus_b.req0_addr  = in_addr[1][0];   assign bus_b.req1_addr  = in_addr[1][1];
  assign bus_b.req0_wdata = in_wdata[1][0];  assign bus_b.req1_wdata = in_wdata[1][1];
  assign bus_b.req0_load_type = in_lt[1][0]; assign bus_b.req1_load_type = in_lt[1][1];
  assign bus_b.dm_read_data = in_rd[1];

  assign o_ready[0][0] = bus_a.req0_ready; assign o_ready[0][1] = bus_a.req1_ready;
  assign o_rv[0][0]    = bus_a.rsp0_valid; assign o_rv[0][1]    = bus_a.rsp1_valid;
  assign o_rd[0][0]    = bus_a.rsp0_rdata; assign o_rd[0][1]    = bus_a.rsp1_rdata;
  assign o_re[0] = bus_a.dm_read_enable;   assign o_we[0] = bus_a.dm_write_enable;
  assign o_addr[0] = bus_a.dm_addr;        assign o_wd[0] = bus_a.dm_write_data;
  assign o_lt[0] = bus_a.dm_load_type;     assign o_busy[0] = bus_a.busy;
  assign o_ready[1][0] = bus_b.req0_ready; assign o_ready[1][1] = bus_b.req1_ready;
  assign o_rv[1][0]    = bus_b.rsp0_valid; assign o_rv[1][1]    = bus_b.rsp1_valid;
  assign o_rd[1][0]    = bus_b.rsp0_rdata; assign o_rd[1][1]    = bus_b.rsp1_rdata;
  assign o_re[1] = bus_b.dm_read_enable;   assign o_we[1] = bus_b.dm_write_enable;
  assign o_addr[1] = bus_b.dm_addr;        assign o_wd[1] = bus_b.dm_write_data;
  assign o_lt[1] = bus_b.dm_load_type;     assign o_busy[1] = bus_b.busy;

  // Model: one outstanding transaction per DUT, described by its grant cycle.
  logic        m_act  [2];
  int          m_c0   [2];
  logic        m_own  [2];
  logic        m_we   [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_wd   [2];
  logic [2:0]  m_lt   [2];
  logic [63:0] m_rsp  [2];
  logic        m_last [2];
  logic        pend   [2][2];

  int cyc;
  int n_cmp;
  int n_bad;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk1(input int d, input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %b expected %b (cycle %0d)", d, nm, act, exp, cyc);
    end
  endtask

  task automatic chk64(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", d, nm, act, exp, cyc);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called #1 after a negedge once the cycle's inputs are driven: compares
  // every output of both DUTs with the model, then advances the model.
  task automatic check_cycle();
    logic        e_r [2];
    logic        acc;
    logic        resp;
    logic [63:0] z;
    int          k;
    int          ld;
    #1;
    z = 64'd0;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d]  = 1'b0;
        m_last[d] = 1'b1;
      end
      e_r[0] = 1'b0;
      e_r[1] = 1'b0;
      if (rst_n && !m_act[d]) begin
        if (in_valid[d][0] && in_valid[d][1]) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
          if (m_last[d]) e_r[0] = 1'b1;
          else           e_r[1] = 1'b1;
`else
          e_r[0] = 1'b1;
`endif
        end else if (in_valid[d][0]) begin
          e_r[0] = 1'b1;
        end else if (in_valid[d][1]) begin
          e_r[1] = 1'b1;
        end
      end
      ld   = lat(d);
      k    = cyc - m_c0[d];
      acc  = m_act[d] && (k >= 1) && (k <= ld);
      resp = m_act[d] && (k == ld + 1);
      chk1(d, "ready0", o_ready[d][0], e_r[0]);
      chk1(d, "ready1", o_ready[d][1], e_r[1]);
      chk1(d, "busy", o_busy[d], m_act[d]);
      chk1(d, "dm_read_enable", o_re[d], acc && !m_we[d]);
      chk1(d, "dm_write_enable", o_we[d], acc && m_we[d]);
      chk64(d, "dm_addr", o_addr[d], acc ? m_addr[d] : z);
      chk64(d, "dm_write_data", o_wd[d], acc ? m_wd[d] : z);
      chk64(d, "dm_load_type", {61'd0, o_lt[d]}, acc ? {61'd0, m_lt[d]} : z);
      chk1(d, "rsp0_valid", o_rv[d][0], resp && !m_own[d]);
      chk1(d, "rsp1_valid", o_rv[d][1], resp && m_own[d]);
      chk64(d, "rsp0_rdata", o_rd[d][0], (resp && !m_own[d]) ? m_rsp[d] : z);
      chk64(d, "rsp1_rdata", o_rd[d][1], (resp && m_own[d]) ? m_rsp[d] : z);
      if (acc && k == ld) m_rsp[d] = m_we[d] ? 64'd0 : in_rd[d];
      if (resp) m_act[d] = 1'b0;
      if (e_r[0] || e_r[1]) begin
        m_own[d]  = e_r[1];
        m_act[d]  = 1'b1;
        m_c0[d]   = cyc;
        m_we[d]   = in_we[d][e_r[1]];
        m_addr[d] = in_addr[d][e_r[1]];
        m_wd[d]   = in_wdata[d][e_r[1]];
        m_lt[d]   = in_lt[d][e_r[1]];
        m_last[d] = e_r[1];
        pend[d][e_r[1]] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic set_req(input int d, input int p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] lt);
    in_valid[d][p] = 1'b1;
    in_we[d][p]    = we;
    in_addr[d][p]  = addr;
    in_wdata[d][p] = wdata;
    in_lt[d][p]    = lt;
  endtask

  task automatic clear_valids();
    for (int d = 0; d < 2; d++) begin
      in_valid[d][0] = 1'b0;
      in_valid[d][1] = 1'b0;
      pend[d][0]     = 1'b0;
      pend[d][1]     = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_valids();
      in_rd[0] = {$urandom, $urandom};
      in_rd[1] = {$urandom, $urandom};
      check_cycle();
    end
  endtask

  // Random requesters that obey hold-until-ready, with occasional withdrawal.
  task automatic gen_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[d][p]) begin
          if ($urandom_range(0, 19) == 0) begin
            pend[d][p]     = 1'b0;
            in_valid[d][p] = 1'b0;
          end else begin
            in_valid[d][p] = 1'b1;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          pend[d][p] = 1'b1;
          set_req(d, p, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  {$urandom, $urandom}, 3'($urandom_range(0, 6)));
        end else begin
          in_valid[d][p] = 1'b0;
        end
      end
      in_rd[d] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_seq [$];
    int exp_seq [3];
    int grant_cyc;
    int t0;
    int v;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_c0[d] = 0; m_own[d] = 1'b0; m_we[d] = 1'b0;
      m_addr[d] = 64'd0; m_wd[d] = 64'd0; m_lt[d] = 3'd0; m_rsp[d] = 64'd0;
      m_last[d] = 1'b1; in_rd[d] = 64'd0;
      for (int p = 0; p < 2; p++) begin
        in_valid[d][p] = 1'b0; in_we[d][p] = 1'b0; in_addr[d][p] = 64'd0;
        in_wdata[d][p] = 64'd0; in_lt[d][p] = 3'd0; pend[d][p] = 1'b0;
      end
    end

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cycle();
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle();

    // Port 0 load on the latency-1 instance; port 1 store on the latency-3 one.
    @(negedge clk);
    set_req(0, 0, 1'b0, 64'h100, 64'h0, 3'(LOAD_D));
    set_req(1, 1, 1'b1, 64'h40, 64'h55, 3'(LOAD_W));
    in_rd[0] = 64'h1111;
    in_rd[1] = 64'h2222;
    check_cycle();
    chk1(0, "t1 ready0 at accept", o_ready[0][0], 1'b1);
    chk1(1, "t2 ready1 at accept", o_ready[1][1], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      clear_valids();
      in_rd[0] = (i == 1) ? 64'hDEAD : 64'h0BAD;
      in_rd[1] = 64'h7777;
      check_cycle();
      if (i == 1) begin
        chk1(0, "t1 dm_read_enable", o_re[0], 1'b1);
        chk64(0, "t1 dm_addr", o_addr[0], 64'h100);
      end
      if (i == 2) begin
        chk1(0, "t1 rsp0_valid", o_rv[0][0], 1'b1);
        chk64(0, "t1 rsp0_rdata", o_rd[0][0], 64'hDEAD);
        chk1(0, "t1 rsp1_valid", o_rv[0][1], 1'b0);
      end
      if (i <= 3) begin
        chk1(1, "t2 dm_write_enable", o_we[1], 1'b1);
        chk1(1, "t2 dm_read_enable", o_re[1], 1'b0);
        chk64(1, "t2 dm_addr", o_addr[1], 64'h40);
        chk64(1, "t2 dm_write_data", o_wd[1], 64'h55);
      end
      if (i == 4) begin
        chk1(1, "t2 rsp1_valid", o_rv[1][1], 1'b1);
        chk64(1, "t2 rsp1_rdata", o_rd[1][1], 64'h0);
        chk1(1, "t2 rsp0_valid", o_rv[1][0], 1'b0);
      end
    end

    // Both ports valid every cycle from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    check_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle();
`ifdef DM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        set_req(d, 0, 1'b0, 64'h200, 64'h0, 3'(LOAD_H));
        set_req(d, 1, 1'b1, 64'h300, 64'hA5A5, 3'(LOAD_B));
        in_rd[d] = {$urandom, $urandom};
      end
      check_cycle();
      if (o_ready[0][0]) g_seq.push_back(0);
      if (o_ready[0][1]) g_seq.push_back(1);
    end
    chkint("t3 grant count", g_seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      v = (i < g_seq.size()) ? g_seq[i] : 9;
      chkint($sformatf("t3 grant %0d port", i), v, exp_seq[i]);
    end
    idle_cycles(6);

    // Request raised during ACCESS waits until the IDLE after RESP.
    t0 = cyc;
    grant_cyc = -1;
    @(negedge clk);
    set_req(1, 0, 1'b0, 64'h500, 64'h0, 3'(LOAD_WU));
    in_rd[1] = 64'h1234;
    check_cycle();
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      in_valid[1][0] = 1'b0;
      if (grant_cyc < 0) set_req(1, 1, 1'b0, 64'h600, 64'h0, 3'(LOAD_BU));
      else in_valid[1][1] = 1'b0;
      in_rd[1] = {$urandom, $urandom};
      check_cycle();
      if (grant_cyc < 0 && o_ready[1][1]) grant_cyc = cyc - 1 - t0;
    end
    chkint("t4 waiting grant cycle", grant_cyc, 5);
    idle_cycles(6);

    // Asynchronous reset in the middle of ACCESS.
    @(negedge clk);
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 64'h700, 64'h0, 3'(LOAD_D));
    check_cycle();
    @(negedge clk);
    clear_valids();
    check_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "t5 busy in reset", o_busy[d], 1'b0);
      chk1(d, "t5 dm_read_enable in reset", o_re[d], 1'b0);
      chk64(d, "t5 dm_addr in reset", o_addr[d], 64'h0);
      chk1(d, "t5 rsp0_valid in reset", o_rv[d][0], 1'b0);
      chk1(d, "t5 rsp1_valid in reset", o_rv[d][1], 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_cycle();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b1, 64'h800, 64'h99, 3'(LOAD_B));
      set_req(d, 1, 1'b0, 64'h900, 64'h0, 3'(LOAD_H));
    end
    check_cycle();
    for (int d = 0; d < 2; d++) begin
      chk1(d, "t5 port0 first after reset", o_ready[d][0], 1'b1);
      chk1(d, "t5 port1 waits after reset", o_ready[d][1], 1'b0);
    end
    idle_cycles(6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      gen_inputs();
      check_cycle();
    end
    idle_cycles(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Sequences and shares the single data-memory access path between two requesters.
  - Port 0 is the pipeline MEM-stage load/store.
  - Port 1 is the secondary master (debug/DMA).
- Accepts one request at a time over a valid/ready handshake and holds the address, data and load type stable on the data-memory port for a fixed latency.
- Returns the read data, or a store acknowledge, to the winning requester.
- Sits between the MEM stage and the data-memory access cycle logic. Load sizing stays downstream; this block passes load_type through unchanged.

Parameters:
- XLEN, 64, data and address width.
- MEM_LATENCY, 1, cycles from access start until dm_read_data is valid. Legal range 1..4.

Ports:
- clk  input  1  single clock, all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- reqN_valid  input  1  (N=0,1) request present.
- reqN_ready  output  1  request accepted this cycle when high together with valid.
- reqN_we  input  1  1 = store, 0 = load.
- reqN_addr  input  XLEN  byte address.
- reqN_wdata  input  XLEN  store data.
- reqN_load_type  input  3  load type code from the shared package.
- rspN_valid  output  1  one-cycle response strobe.
- rspN_rdata  output  XLEN  load data; 0 for stores.
- dm_read_enable  output  1  memory read strobe, held for the whole access.
- dm_write_enable  output  1  memory write strobe, held for the whole access.
- dm_addr  output  XLEN  access address.
- dm_write_data  output  XLEN  store data.
- dm_load_type  output  3  passed-through load type.
- dm_read_data  input  XLEN  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, lat_cnt = 0, last_grant = 1 (port 0 wins first).
  - All outputs and captured request registers are 0.
  - An in-flight access is dropped and produces no response.
- State IDLE:
  - reqN_ready is driven combinationally, high only for the arbitration winner; both are 0 if neither requester is valid.
  - Default priority is fixed: port 0 over port 1.
  - On valid&&ready: capture owner, we, addr, wdata and load_type; set lat_cnt = MEM_LATENCY-1; go to ACCESS.
  - dm_* outputs are all 0 in IDLE.
- State ACCESS:
  - dm_addr, dm_write_data and dm_load_type are driven from the captured registers.
  - dm_read_enable = !we and dm_write_enable = we; exactly one is high, never both.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: if load, register dm_read_data into the response data register (stores register 0), then go to RESP.
- State RESP:
  - rsp<owner>_valid = 1 for exactly one cycle with the registered data. The other port's rsp_valid stays 0.
  - rspN_rdata is 0 whenever rspN_valid is 0.
  - Next state is IDLE. The next grant cannot occur in this cycle.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Latency: accept edge to rsp_valid is MEM_LATENCY+1 cycles.
- A requester must hold valid and its payload until ready. Deasserting valid before ready is legal and simply withdraws the request.
- The block never overlaps accesses. Any request arriving while busy waits with ready = 0.
- Simultaneous valid from both ports in IDLE: the winner is taken per the priority rule and the loser stays pending with ready = 0.

Optional Feature:
- Macro: DM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, the port that is not last_grant wins.
  - last_grant updates on every accept.
  - With a single requester, that requester always wins.
- Undefined:
  - Fixed priority, port 0 always wins.
  - last_grant is unused; synthesis may remove it.

Decomposition:
- Shared package dm_pkg holds:
  - load type enum: LOAD_B=0, LOAD_H=1, LOAD_W=2, LOAD_BU=3, LOAD_HU=4, LOAD_WU=5, LOAD_D=6;
  - arbiter state enum {IDLE, ACCESS, RESP};
  - a typedef packed struct dm_req_t {we, addr, wdata, load_type}.
- One sub-module is natural: dm_arb_select, the combinational winner/grant logic including the round-robin option. The FSM and registers stay in the top.

Test Plan:
- Port 0 load, addr 0x100, MEM_LATENCY 1, dm_read_data 0xDEAD -> ready0 in cycle 0; dm_read_enable=1 in cycle 1; rsp0_valid=1 with rdata=0xDEAD in cycle 2; rsp1_valid stays 0.
- Port 1 store, addr 0x40, wdata 0x55, MEM_LATENCY 3 -> dm_write_enable=1 with addr 0x40 and data 0x55 for 3 cycles; then rsp1_valid=1 with rdata=0; dm_read_enable stays 0 throughout.
- Both ports valid every cycle, fixed priority -> grants 0,0,0; port 1 ready stays 0. With DM_ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1.
- Request asserted during ACCESS -> ready stays 0 until the IDLE cycle after RESP; the next dm access starts no earlier than cycle MEM_LATENCY+2.
- rst_n pulsed low mid-ACCESS -> all outputs 0 immediately (asynchronously); no rsp_valid; a port 0 request after release is granted first.
